// File: rtl/alu_instr_sequencer_pkg.sv
// Shared constants, instruction layout and FSM encoding for the ALU instruction sequencer.
// The register-file/ALU datapath and the testbench both rely on these definitions.
package alu_instr_sequencer_pkg;

   localparam int unsigned INSTR_WIDTH  = 16;
   localparam int unsigned RESULT_WIDTH = 8;
   localparam int unsigned REG_AW       = 3;
   localparam int unsigned DATA_W       = 4;
   localparam int unsigned FUNC_W       = 4;
   localparam int unsigned OP_W         = 3;

   localparam int unsigned REGW_LSB = 13;
   localparam int unsigned REG1_LSB = 10;
   localparam int unsigned REG2_LSB = 7;
   localparam int unsigned FUNC_LSB = 3;
   localparam int unsigned OP_LSB   = 0;

   localparam logic [OP_W-1:0] OP_NOP = 3'b000;
   localparam logic [OP_W-1:0] OP_CMP = 3'b001;
   localparam logic [OP_W-1:0] OP_ALU = 3'b011;

   typedef enum logic [FUNC_W-1:0] {
      FN_AND  = 4'h0,
      FN_OR   = 4'h1,
      FN_XOR  = 4'h2,
      FN_NAND = 4'h3,
      FN_NOR  = 4'h4,
      FN_XNOR = 4'h5,
      FN_ADD  = 4'h6,
      FN_SUB  = 4'h7,
      FN_MUL  = 4'h8,
      FN_EQ   = 4'h9,
      FN_LT   = 4'hA,
      FN_GT   = 4'hB,
      FN_NOTA = 4'hC,
      FN_INC  = 4'hD,
      FN_SHL  = 4'hE,
      FN_SHR  = 4'hF
   } alu_func_e;

   // Field order mirrors the bit positions above (MSB first).
   typedef struct packed {
      logic [REG_AW-1:0] regw;
      logic [REG_AW-1:0] reg1;
      logic [REG_AW-1:0] reg2;
      logic [FUNC_W-1:0] func;
      logic [OP_W-1:0]   op;
   } instr_t;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_READ = 3'd1;
   localparam logic [2:0] ST_OPND = 3'd2;
   localparam logic [2:0] ST_EXEC = 3'd3;
   localparam logic [2:0] ST_WB   = 3'd4;
   localparam logic [2:0] ST_RESP = 3'd5;

   function automatic logic op_is_legal(logic [OP_W-1:0] op);
      return (op == OP_NOP) || (op == OP_CMP) || (op == OP_ALU);
   endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Instruction and result valid/ready channels of the sequencer.
// master = instruction producer / result consumer, slave = sequencer.
interface alu_instr_sequencer_if;
   import alu_instr_sequencer_pkg::*;

   logic                    inst_valid;
   logic                    inst_ready;
   logic [INSTR_WIDTH-1:0]  inst_data;
   logic                    res_valid;
   logic                    res_ready;
   logic [RESULT_WIDTH-1:0] res_data;
   logic                    res_zero;
   logic                    res_err;

   modport master (
      output inst_valid, inst_data, res_ready,
      input  inst_ready, res_valid, res_data, res_zero, res_err
   );

   modport slave (
      input  inst_valid, inst_data, res_ready,
      output inst_ready, res_valid, res_data, res_zero, res_err
   );

endinterface

// File: rtl/alu_instr_sequencer_instr_fifo.sv
// Instruction buffer: power-of-two depth, no bypass, flush overrides push and pop.
module alu_instr_sequencer_instr_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W:0]   o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full & ~i_flush;
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle sequencer: buffers instructions, then steps each through register read,
// operand latch, execute, writeback and response against an external register file and ALU.
module alu_instr_sequencer
   import alu_instr_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned INST_W     = 16,
   parameter int unsigned RES_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_instr_sequencer_if.slave  bus,
   input  logic                  i_flush,
   output logic [REG_AW-1:0]     o_rf_raddr1,
   output logic [REG_AW-1:0]     o_rf_raddr2,
   input  logic [DATA_W-1:0]     i_rf_rdata1,
   input  logic [DATA_W-1:0]     i_rf_rdata2,
   output logic                  o_rf_we,
   output logic [REG_AW-1:0]     o_rf_waddr,
   output logic [RES_W-1:0]      o_rf_wdata,
   output logic [FUNC_W-1:0]     o_alu_func,
   output logic [DATA_W-1:0]     o_alu_in1,
   output logic [DATA_W-1:0]     o_alu_in2,
   input  logic [RES_W-1:0]      i_alu_result,
   input  logic                  i_alu_zero,
   output logic                  o_busy
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [INST_W-1:0] w_fifo_rdata;
   logic [CNT_W-1:0]  w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   instr_t            w_head;
   logic              w_head_legal;

   logic [2:0]        r_state;
   logic [2:0]        w_state_next;
   instr_t            r_inst;
   logic [RES_W-1:0]  r_result;
   logic              r_zero;
   logic              r_err;
   logic [DATA_W-1:0] r_alu_in1;
   logic [DATA_W-1:0] r_alu_in2;

   assign w_push = bus.inst_valid & ~w_full;
   // A flush in IDLE discards the head entry instead of issuing it.
   assign w_pop  = (r_state == ST_IDLE) & ~w_empty & ~i_flush;

   alu_instr_sequencer_instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INST_W)
   ) u_instr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_flush),
      .i_wdata (bus.inst_data),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_head       = instr_t'(w_fifo_rdata);
   assign w_head_legal = op_is_legal(w_head.op);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pop) begin
               if (w_head.op == OP_NOP) w_state_next = ST_IDLE;
               else if (!w_head_legal)  w_state_next = ST_RESP;
               else                     w_state_next = ST_READ;
            end
         end
         ST_READ: w_state_next = ST_OPND;
         ST_OPND: w_state_next = ST_EXEC;
         ST_EXEC: w_state_next = ST_WB;
         ST_WB:   w_state_next = ST_RESP;
         ST_RESP: if (bus.res_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst    <= '0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_err     <= 1'b0;
         r_alu_in1 <= '0;
         r_alu_in2 <= '0;
      end else begin
         if (w_pop) begin
            r_inst <= w_head;
            r_err  <= ~w_head_legal;
            if (!w_head_legal) begin
               r_result <= '0;
               r_zero   <= 1'b0;
            end
         end
         if (r_state == ST_OPND) begin
            r_alu_in1 <= i_rf_rdata1;
            r_alu_in2 <= i_rf_rdata2;
         end
         if (r_state == ST_EXEC) begin
            r_result <= i_alu_result;
            r_zero   <= i_alu_zero;
         end
      end
   end

   // Addresses and function select track inst_q in every state; only their
   // READ/EXEC/WB values matter to the datapath.
   assign o_rf_raddr1 = r_inst.reg1;
   assign o_rf_raddr2 = r_inst.reg2;
   assign o_rf_waddr  = r_inst.regw;
   assign o_rf_wdata  = r_result;
   assign o_rf_we     = (r_state == ST_WB) & (r_inst.op == OP_ALU);
   assign o_alu_func  = r_inst.func;
   assign o_alu_in1   = r_alu_in1;
   assign o_alu_in2   = r_alu_in2;

   assign bus.inst_ready = ~w_full;
   assign bus.res_valid  = (r_state == ST_RESP);
   assign bus.res_data   = r_result;
   assign bus.res_zero   = r_zero;
   assign bus.res_err    = r_err;

   assign o_busy = (r_state != ST_IDLE) | (w_count != '0);

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench: register-file and ALU models around the sequencer, with a
// reference model that executes instructions in order against a shadow register array.
module tb_alu_instr_sequencer;
   import alu_instr_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       rf_rst = 1'b0;
   logic       flush = 1'b0;
   logic [2:0] rf_raddr1, rf_raddr2, rf_waddr;
   logic [3:0] rf_rdata1, rf_rdata2, alu_func, alu_in1, alu_in2;
   logic       rf_we, alu_zero, busy;
   logic [7:0] rf_wdata, alu_result;

   alu_instr_sequencer_if bus();

   alu_instr_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .i_flush      (flush),
      .o_rf_raddr1  (rf_raddr1),
      .o_rf_raddr2  (rf_raddr2),
      .i_rf_rdata1  (rf_rdata1),
      .i_rf_rdata2  (rf_rdata2),
      .o_rf_we      (rf_we),
      .o_rf_waddr   (rf_waddr),
      .o_rf_wdata   (rf_wdata),
      .o_alu_func   (alu_func),
      .o_alu_in1    (alu_in1),
      .o_alu_in2    (alu_in2),
      .i_alu_result (alu_result),
      .i_alu_zero   (alu_zero),
      .o_busy       (busy)
   );

   function automatic logic [7:0] alu_fn(logic [3:0] f, logic [3:0] a, logic [3:0] b);
      case (f)
         FN_AND:  return {4'h0, a & b};
         FN_OR:   return {4'h0, a | b};
         FN_XOR:  return {4'h0, a ^ b};
         FN_NAND: return {4'h0, ~(a & b)};
         FN_NOR:  return {4'h0, ~(a | b)};
         FN_XNOR: return {4'h0, ~(a ^ b)};
         FN_ADD:  return {4'h0, a} + {4'h0, b};
         FN_SUB:  return {4'h0, a} - {4'h0, b};
         FN_MUL:  return {4'h0, a} * {4'h0, b};
         FN_EQ:   return {7'd0, a == b};
         FN_LT:   return {7'd0, a < b};
         FN_GT:   return {7'd0, a > b};
         FN_NOTA: return {4'h0, ~a};
         FN_INC:  return {4'h0, a} + 8'd1;
         FN_SHL:  return {4'h0, a} << b[1:0];
         default: return {4'h0, a >> b[1:0]};
      endcase
   endfunction

   always_comb begin
      alu_result = alu_fn(alu_func, alu_in1, alu_in2);
      alu_zero   = (alu_result == 8'd0);
   end

   // Register file with registered read ports; its reset is independent of the DUT's.
   logic [3:0] rf_mem [8];
   always @(posedge clk or posedge rf_rst) begin
      if (rf_rst) begin
         for (int i = 0; i < 8; i++) rf_mem[i] <= 4'(i);
         rf_rdata1 <= 4'h0;
         rf_rdata2 <= 4'h0;
      end else begin
         if (rf_we) begin
            rf_mem[rf_waddr]        <= rf_wdata[3:0];
            rf_mem[rf_waddr + 3'd1] <= rf_wdata[7:4];
         end
         rf_rdata1 <= rf_mem[rf_raddr1];
         rf_rdata2 <= rf_mem[rf_raddr2];
      end
   end

   int   we_count = 0;
   int   we_long = 0;
   logic we_prev = 1'b0;
   always @(negedge clk) begin
      if (rf_we) begin
         we_count <= we_count + 1;
         if (we_prev) we_long <= we_long + 1;
      end
      we_prev <= rf_we;
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d;
      logic       z;
      logic       e;
   } exp_t;
   exp_t       exp_q[$];
   logic [3:0] ref_regs [8];

   function automatic logic [15:0] mk(int regw, int r1, int r2, int f, int op);
      return {3'(regw), 3'(r1), 3'(r2), 4'(f), 3'(op)};
   endfunction

   // Architectural effect of one instruction, applied in program order.
   task automatic model_exec(input logic [15:0] inst, output bit has_resp, output exp_t x);
      int op, rw;
      logic [7:0] r;
      op = int'(inst[2:0]);
      rw = int'(inst[15:13]);
      has_resp = (op != 0);
      x.e = !(op == 0 || op == 1 || op == 3);
      x.d = 8'h00;
      x.z = 1'b0;
      if (op == 1 || op == 3) begin
         r   = alu_fn(inst[6:3], ref_regs[inst[12:10]], ref_regs[inst[9:7]]);
         x.d = r;
         x.z = (r == 8'h00);
         if (op == 3) begin
            ref_regs[rw]           = r[3:0];
            ref_regs[(rw + 1) % 8] = r[7:4];
         end
      end
   endtask

   task automatic send(input logic [15:0] d, output bit acc);
      acc = 1'b0;
      bus.inst_valid = 1'b1;
      bus.inst_data  = d;
      for (int i = 0; i < 100; i++) begin
         if (bus.inst_ready) begin
            acc = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.inst_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_accept inst=%h got inst_ready=0 for 100 cycles, want accept", d);
      end
   endtask

   task automatic recv(input int delay, output exp_t r, output bit got);
      got = 1'b0;
      r.d = 8'hxx;
      r.z = 1'bx;
      r.e = 1'bx;
      bus.res_ready = 1'b0;
      repeat (delay) @(negedge clk);
      bus.res_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (bus.res_valid) begin
            r.d = bus.res_data;
            r.z = bus.res_zero;
            r.e = bus.res_err;
            got = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.inst_valid = 1'b0;
      bus.inst_data  = 16'h0;
      bus.res_ready  = 1'b0;
      rst_n  = 1'b0;
      rf_rst = 1'b1;
      for (int i = 0; i < 8; i++) ref_regs[i] = 4'(i);
      @(negedge clk);
      rf_rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.inst_ready, bus.res_valid, bus.res_data, bus.res_zero, bus.res_err, rf_we, busy}
          !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b vld=%b data=%h z=%b err=%b we=%b busy=%b want 1 0 00 0 0 0 0",
                  bus.inst_ready, bus.res_valid, bus.res_data, bus.res_zero, bus.res_err, rf_we, busy);
      end
      checks++;
      if ({rf_wdata, alu_in1, alu_in2, alu_func} !== 20'h0) begin
         errors++;
         $display("FAIL reset_datapath got wdata=%h in1=%h in2=%h func=%h want all 0",
                  rf_wdata, alu_in1, alu_in2, alu_func);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.inst_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b busy=%b want 1 0", bus.inst_ready, busy);
      end
   endtask

   task automatic test_add_latency();
      logic [15:0] inst;
      bit has, acc, got;
      exp_t x, r;
      inst = 16'h0EB3;
      model_exec(inst, has, x);
      send(inst, acc);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++;
         if (bus.res_valid !== (k == 5)) begin
            errors++;
            $display("FAIL add_latency edge=%0d got res_valid=%b want %b", k, bus.res_valid, k == 5);
         end
         checks++;
         if (k == 4 && {rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd0, 8'h08}) begin
            errors++;
            $display("FAIL add_wb got we=%b waddr=%0d wdata=%h want 1 0 08", rf_we, rf_waddr, rf_wdata);
         end else if (k != 4 && rf_we !== 1'b0) begin
            errors++;
            $display("FAIL add_we_pulse edge=%0d got rf_we=%b want 0", k, rf_we);
         end
      end
      recv(0, r, got);
      checks++;
      if (!got || r.d !== 8'h08 || r.z !== 1'b0 || r.e !== 1'b0 || x.d !== 8'h08) begin
         errors++;
         $display("FAIL add_result got=%b data=%h z=%b err=%b want data=08 z=0 err=0", got, r.d, r.z, r.e);
      end
      checks++;
      if (rf_mem[0] !== 4'h8 || rf_mem[1] !== 4'h0) begin
         errors++;
         $display("FAIL add_regs got r0=%h r1=%h want r0=8 r1=0", rf_mem[0], rf_mem[1]);
      end
   endtask

   task automatic test_mul_wrap();
      logic [15:0] inst;
      bit has, acc, got;
      exp_t x, r;
      inst = mk(7, 7, 6, FN_MUL, 3);
      model_exec(inst, has, x);
      send(inst, acc);
      recv(2, r, got);
      checks++;
      if (!got || r.d !== 8'h2A || r.z !== 1'b0 || r.e !== 1'b0) begin
         errors++;
         $display("FAIL mul_result got=%b data=%h z=%b err=%b want data=2a z=0 err=0", got, r.d, r.z, r.e);
      end
      checks++;
      if (rf_mem[7] !== 4'hA || rf_mem[0] !== 4'h2) begin
         errors++;
         $display("FAIL mul_wrap_regs got r7=%h r0=%h want r7=a r0=2", rf_mem[7], rf_mem[0]);
      end
   endtask

   task automatic test_compare();
      bit has, acc, got;
      exp_t x, r;
      int we0;
      we0 = we_count;
      model_exec(mk(0, 4, 4, FN_EQ, 1), has, x);
      send(mk(0, 4, 4, FN_EQ, 1), acc);
      recv(0, r, got);
      checks++;
      if (!got || r.d !== 8'h01 || r.z !== 1'b0 || r.e !== 1'b0) begin
         errors++;
         $display("FAIL cmp_eq got=%b data=%h z=%b err=%b want data=01 z=0 err=0", got, r.d, r.z, r.e);
      end
      model_exec(mk(0, 4, 4, FN_XOR, 1), has, x);
      send(mk(0, 4, 4, FN_XOR, 1), acc);
      recv(1, r, got);
      checks++;
      if (!got || r.d !== 8'h00 || r.z !== 1'b1 || r.e !== 1'b0) begin
         errors++;
         $display("FAIL cmp_xor got=%b data=%h z=%b err=%b want data=00 z=1 err=0", got, r.d, r.z, r.e);
      end
      checks++;
      if (we_count !== we0) begin
         errors++;
         $display("FAIL cmp_no_wb got rf_we pulses=%0d want 0", we_count - we0);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] insts [6];
      bit has, got;
      exp_t x, r;
      int idx;
      for (int i = 0; i < 6; i++)
         insts[i] = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 15), ($urandom_range(0, 1) == 0) ? 1 : 3);
      bus.res_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         bus.inst_valid = (idx < 6);
         if (idx < 6) bus.inst_data = insts[idx];
         if (idx < 6 && bus.inst_ready) begin
            model_exec(insts[idx], has, x);
            exp_q.push_back(x);
            idx++;
         end
         @(negedge clk);
      end
      checks++;
      if (idx != 5 || bus.inst_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept got accepted=%0d inst_ready=%b want 5 0", idx, bus.inst_ready);
      end
      bus.inst_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== exp_q[0].d) begin
            errors++;
            $display("FAIL bp_stall_hold got vld=%b data=%h want 1 %h", bus.res_valid, bus.res_data,
                     exp_q[0].d);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         recv($urandom_range(0, 2), r, got);
         x = exp_q.pop_front();
         checks++;
         if (!got || r.d !== x.d || r.z !== x.z || r.e !== x.e) begin
            errors++;
            $display("FAIL bp_drain[%0d] got=%b data=%h z=%b err=%b want %h %b %b",
                     i, got, r.d, r.z, r.e, x.d, x.z, x.e);
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_idle got busy=%b vld=%b want 0 0", busy, bus.res_valid);
      end
   endtask

   task automatic test_nop_illegal();
      bit has, acc, got, saw;
      exp_t x, r;
      int we0;
      we0 = we_count;
      send(mk(1, 2, 3, FN_ADD, 0), acc);
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.res_valid) saw = 1'b1;
      end
      checks++;
      if (saw || busy !== 1'b0 || we_count !== we0) begin
         errors++;
         $display("FAIL nop_silent got resp=%b busy=%b we_pulses=%0d want 0 0 0", saw, busy,
                  we_count - we0);
      end
      model_exec(mk(5, 1, 2, FN_ADD, 7), has, x);
      send(mk(5, 1, 2, FN_ADD, 7), acc);
      recv(1, r, got);
      checks++;
      if (!got || r.e !== 1'b1 || r.d !== 8'h00 || we_count !== we0) begin
         errors++;
         $display("FAIL illegal_op got=%b err=%b data=%h we_pulses=%0d want err=1 data=00 we=0",
                  got, r.e, r.d, we_count - we0);
      end
   endtask

   task automatic test_flush();
      bit has, acc, got, saw;
      exp_t x, r;
      logic [15:0] inst;
      bus.res_ready = 1'b0;
      inst = mk(2, 1, 3, FN_SUB, 3);
      model_exec(inst, has, x);
      send(inst, acc);
      saw = 1'b0;
      for (int i = 0; i < 20 && !saw; i++) begin
         if (bus.res_valid) saw = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!saw) begin
         errors++;
         $display("FAIL flush_reach_resp got res_valid=0 for 20 cycles want 1");
      end
      for (int i = 0; i < 3; i++) send(mk(i, i, i, FN_OR, 1), acc);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      recv(0, r, got);
      checks++;
      if (!got || r.d !== x.d || r.z !== x.z || r.e !== 1'b0) begin
         errors++;
         $display("FAIL flush_inflight got=%b data=%h z=%b err=%b want %h %b 0", got, r.d, r.z, r.e,
                  x.d, x.z);
      end
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.res_valid) saw = 1'b1;
      end
      checks++;
      if (saw || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty got extra_resp=%b busy=%b want 0 0", saw, busy);
      end
   endtask

   task automatic test_reset_mid();
      bit has, acc, got, saw;
      exp_t x, r;
      send(mk(2, 3, 5, FN_ADD, 3), acc);
      send(mk(0, 1, 1, FN_AND, 1), acc);
      send(mk(0, 2, 2, FN_AND, 1), acc);
      saw = 1'b0;
      for (int i = 0; i < 20 && !saw; i++) begin
         if (rf_we) saw = 1'b1;
         else @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (!saw || rf_we !== 1'b0 || bus.res_valid !== 1'b0 || bus.inst_ready !== 1'b1 ||
          busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got saw_wb=%b we=%b vld=%b rdy=%b busy=%b want 1 0 0 1 0",
                  saw, rf_we, bus.res_valid, bus.inst_ready, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.res_valid || busy) saw = 1'b1;
      end
      checks++;
      if (saw) begin
         errors++;
         $display("FAIL reset_fifo_empty got activity after reset=1 want 0");
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rf_mem[i] !== ref_regs[i]) begin
            errors++;
            $display("FAIL reset_no_write r%0d got %h want %h", i, rf_mem[i], ref_regs[i]);
         end
      end
      model_exec(mk(4, 3, 5, FN_ADD, 3), has, x);
      send(mk(4, 3, 5, FN_ADD, 3), acc);
      recv(0, r, got);
      checks++;
      if (!got || r.d !== x.d || r.z !== x.z || r.e !== 1'b0) begin
         errors++;
         $display("FAIL reset_after_add got=%b data=%h z=%b err=%b want %h %b 0", got, r.d, r.z, r.e,
                  x.d, x.z);
      end
   endtask

   task automatic test_random();
      bit has, acc, got, saw;
      exp_t x, r;
      logic [15:0] inst;
      int sel, op;
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) op = 0;
         else if (sel <= 2) begin
            op = $urandom_range(2, 7);
            if (op == 3) op = 7;
         end else if (sel <= 5) op = 1;
         else op = 3;
         inst = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 15), op);
         model_exec(inst, has, x);
         send(inst, acc);
         checks++;
         if (has) begin
            recv($urandom_range(0, 3), r, got);
            if (!got || r.d !== x.d || r.e !== x.e || (!x.e && r.z !== x.z)) begin
               errors++;
               $display("FAIL random[%0d] inst=%h got=%b data=%h z=%b err=%b want %h %b %b",
                        n, inst, got, r.d, r.z, r.e, x.d, x.z, x.e);
            end
         end else begin
            saw = 1'b0;
            repeat (8) begin
               @(negedge clk);
               if (bus.res_valid) saw = 1'b1;
            end
            if (saw || busy !== 1'b0) begin
               errors++;
               $display("FAIL random_nop[%0d] got resp=%b busy=%b want 0 0", n, saw, busy);
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rf_mem[i] !== ref_regs[i]) begin
            errors++;
            $display("FAIL random_regs r%0d got %h want %h", i, rf_mem[i], ref_regs[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      fork
         begin
            bit has, acc;
            exp_t x;
            logic [15:0] inst;
            for (int n = 0; n < 12; n++) begin
               inst = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 15), ($urandom_range(0, 1) == 0) ? 1 : 3);
               send(inst, acc);
               if (acc) begin
                  model_exec(inst, has, x);
                  exp_q.push_back(x);
               end
            end
         end
         begin
            bit got;
            exp_t r, x;
            for (int n = 0; n < 12; n++) begin
               recv($urandom_range(0, 1), r, got);
               checks++;
               if (!got || exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL b2b_resp[%0d] got=%b queued=%0d want response and expectation",
                           n, got, exp_q.size());
               end else begin
                  x = exp_q.pop_front();
                  if (r.d !== x.d || r.z !== x.z || r.e !== x.e) begin
                     errors++;
                     $display("FAIL b2b_data[%0d] got %h %b %b want %h %b %b", n, r.d, r.z, r.e,
                              x.d, x.z, x.e);
                  end
               end
            end
         end
      join
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drained got leftover=%0d busy=%b want 0 0", exp_q.size(), busy);
      end
      checks++;
      if (we_long != 0) begin
         errors++;
         $display("FAIL we_single_cycle got %0d extended pulses want 0", we_long);
      end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_mul_wrap();
      test_compare();
      test_backpressure();
      test_nop_illegal();
      test_flush();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Multi-cycle controller that sequences the 8x4-bit register file and the 16-function 4-bit ALU of the pin-fed processor core.
Accepts 16-bit instructions over a valid/ready handshake and buffers them in a small FIFO.
Steps each instruction through register read, execute and writeback, then returns the 8-bit result and zero flag over a second valid/ready handshake.
Sits between the pin interface and the existing register-file/ALU datapath, replacing the direct pin-to-decode path.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2
INST_W, 16, instruction width; field layout is fixed, so only 16 is legal
RES_W, 8, ALU result width

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  instruction offered
inst_ready  out  1  FIFO can accept; equals !full
inst_data  in  16  {regw[15:13], reg1[12:10], reg2[9:7], func[6:3], opcode[2:0]}
flush  in  1  synchronous; empties FIFO; in-flight instruction completes
rf_raddr1  out  3  register file read port 1 address (reg1)
rf_raddr2  out  3  register file read port 2 address (reg2)
rf_rdata1  in  4  read data 1; register file registers it, so valid one cycle after address
rf_rdata2  in  4  read data 2; same timing
rf_we  out  1  write enable; single-cycle pulse
rf_waddr  out  3  write base register (regw)
rf_wdata  out  8  write data; low nibble to regw, high nibble to (regw+1) mod 8
alu_func  out  4  ALU function select
alu_in1  out  4  registered operand 1
alu_in2  out  4  registered operand 2
alu_result  in  8  combinational ALU result
alu_zero  in  1  combinational ALU zero flag
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  8  result
res_zero  out  1  zero flag of the result
res_err  out  1  set when the instruction had an illegal opcode
busy  out  1  high when FSM is not IDLE or FIFO is not empty

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; FIFO is emptied (count=0, pointers=0).
  - All outputs are 0 except inst_ready=1.
  - An instruction in flight at reset is aborted; rf_we is never asserted for it.
- FIFO:
  - Push when inst_valid & inst_ready.
  - Pop only in IDLE when the FIFO is non-empty.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - There is no bypass: an instruction written into an empty FIFO is popped on the next cycle at the earliest.
  - flush clears count and pointers; flush wins over a same-cycle push.
- Opcodes:
  - 3'b011: ALU operation with writeback.
  - 3'b001: ALU operation, no writeback.
  - 3'b000: NOP; consumed, produces no response.
  - All other opcodes: illegal.
- FSM states and transitions:
  - IDLE: on non-empty FIFO, pop into inst_q. NOP -> IDLE. Illegal -> RESP with err_q=1 and result_q=0. Otherwise -> READ.
  - READ: drive rf_raddr1/2 from inst_q -> OPND.
  - OPND: latch rf_rdata1/2 into alu_in1/2 -> EXEC.
  - EXEC: alu_func=func; capture alu_result and alu_zero into result_q/zero_q -> WB.
  - WB: rf_we=1 only for opcode 011, with rf_waddr=regw and rf_wdata=result_q -> RESP.
  - RESP: res_valid=1 and outputs held stable until res_ready=1 -> IDLE.
- Addresses and ALU selects are driven from inst_q in every state; they are don't-care outside READ/EXEC/WB.
- Latency: accept at edge 0 into an idle, empty block -> res_valid high after edge 5. Minimum throughput is 1 result per 6 cycles.
- Write wrap: regw=7 writes r7 (low nibble) and r0 (high nibble). This is the register file's responsibility; the sequencer only supplies the base address.
- Execution is strictly sequential, so there are no data hazards; a following instruction reads the written value.
- flush during READ..RESP does not affect the current instruction.

Decomposition:
- Shared package holds:
  - opcode constants OP_NOP=000, OP_CMP=001, OP_ALU=011;
  - the 4-bit ALU function codes (AND=0000 ... SHR=1111);
  - instruction field bit-position constants;
  - the FSM state enum (IDLE, READ, OPND, EXEC, WB, RESP).
- One sub-module is natural: instr_fifo (parameterised depth, width 16, push/pop/flush, full/empty/count).

Test Plan:
(Bench connects a register-file model reset to r_i=i and a behavioural ALU.)
- ADD with writeback: push 0x0EB3 (regw=0, reg1=3, reg2=5, ADD) -> res_data=0x08, res_zero=0, res_valid 5 cycles after accept; a single-cycle rf_we pulse writes r0=8, r1=0.
- MUL with writeback wrap: push regw=7, reg1=7, reg2=6, func=1000, op=011 -> res_data=0x2A; r7=0xA, r0=0x2.
- Compare without writeback: op=001, EQUAL on r4,r4 -> res_data=0x01, rf_we never asserted. XOR r4,r4 -> res_data=0, res_zero=1.
- Backpressure: hold res_ready=0 and offer 6 instructions. Expect 5 accepted (1 in flight + 4 in FIFO), inst_ready=0 on the 6th. res_data stays stable while stalled. Releasing res_ready drains all 5 in order.
- NOP, illegal opcode and flush: a NOP produces no response. Opcode 111 gives res_err=1, res_data=0. flush with 3 queued instructions while one is in RESP -> only the in-flight result is returned, and busy=0 afterwards.
- Reset mid-operation: drop rst_n during WB -> rf_we=0 immediately, res_valid=0, inst_ready=1, FIFO empty. After release, a new ADD executes correctly.
